ac_e_sequencer: RTL and testbench
=================================

# ac_e_sequencer

Sequencer that owns the Basic Computer accumulator (AC) and extend bit (E) and drives the combinational ALU from the consuming side. It accepts one instruction per handshake, presents operands and OPSEL to the ALU, and writes RESULT/CO back into AC/E. It also evaluates the register-reference skip conditions. It sits between the control unit (commands, DR operand) and the ALU (operands out, result/flags in).

## Interface
- WIDTH, 16, datapath width of AC, DR and ALU operands
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  4  instruction code (see Operation)
- cmd_dr  in  WIDTH  memory operand (DR), used by AND/ADD/LDA
- alu_ac  out  WIDTH  ALU AC operand
- alu_dr  out  WIDTH  ALU DR operand
- alu_e  out  1  ALU E input
- alu_opsel  out  3  ALU operation select
- alu_result  in  WIDTH  ALU result
- alu_co  in  1  ALU carry/shift-out
- alu_ovf  in  1  ALU signed overflow
- ac  out  WIDTH  AC register
- e  out  1  E register
- ovf  out  1  overflow flag from last ADD/INC
- done  out  1  one-cycle completion pulse
- skip  out  1  skip decision, valid only while done=1

## Operation
- cmd_op codes: 0 NOP, 1 AND, 2 ADD, 3 LDA, 4 CLA, 5 CLE, 6 CMA, 7 CME, 8 CIR, 9 CIL, 10 INC, 11 SPA, 12 SNA, 13 SZA, 14 SZE, 15 reserved (executes as NOP).
- Accept on cmd_valid && cmd_ready. cmd_op and cmd_dr are latched into internal op/dr registers on the accepting edge.
- FSM states: IDLE -> EXEC -> DONE -> IDLE. cmd_ready = (state==IDLE) && rst_n.
- EXEC drives the ALU from registers: alu_ac=AC, alu_e=E, alu_dr=dr (INC: alu_dr=1). The write-back below happens on the EXEC->DONE edge.
  - AND: opsel 001, AC<=result.
  - ADD: opsel 000, AC<=result, E<=co, ovf<=alu_ovf.
  - LDA: opsel 010, AC<=result.
  - CMA: opsel 011, AC<=result.
  - CIR: opsel 100, AC<=result, E<=co.
  - CIL: opsel 101, AC<=result, E<=co.
  - INC: opsel 000, AC<=result, ovf<=alu_ovf, E unchanged.
  - CLA: AC<=0. CLE: E<=0. CME: E<=~E. None of these use the ALU result.
  - NOP, skips, reserved: AC/E/ovf unchanged.
- Outside EXEC, and for non-ALU ops: alu_opsel=010 with operands still driven from registers. The ALU output is ignored.
- ovf changes only on ADD/INC.
- skip is computed in EXEC from pre-instruction AC/E and registered for DONE:
  - SPA: AC[WIDTH-1]==0.
  - SNA: AC[WIDTH-1]==1.
  - SZA: AC==0.
  - SZE: E==0.
  - All other ops: skip=0.
- Arithmetic is modulo 2^WIDTH. Carry comes only from the ALU co; it is never recomputed locally.

## Timing
- Reset (rst_n low at an edge): state=IDLE, AC=0, E=0, ovf=0, done=0, skip=0. cmd_ready=0 while rst_n low. Outputs hold these values until the first accepted command completes.
- Latency: accept at edge T0. AC/E updated at T1. done=1 and skip valid during cycle T1–T2. cmd_ready is high again after T2.
- Throughput: one command per 3 cycles. cmd_valid while not ready is ignored, and cmd_op/cmd_dr are not sampled.
- done is high for exactly one cycle per accepted command, including NOP/reserved.
- Reset in EXEC or DONE aborts the command: no write-back and no done pulse. Registers take their reset values on that edge.
- cmd_valid held high continuously: a new command is accepted on every IDLE cycle.

## Test plan
- ADD overflow: LDA dr=0x7FFF, then ADD dr=0x0001 -> AC=0x8000, E=0, ovf=1, done once per command, 3-cycle spacing.
- ADD carry: LDA 0xFFFF, then ADD 0x0001 -> AC=0x0000, E=1, ovf=0. Follow with SZA -> skip=1, then SZE -> skip=0.
- Rotates: set E=1 via CLE,CME; LDA 0x8001; CIL -> AC=0x0003, E=1. CLE; LDA 0x0001; CIR -> AC=0x0000, E=1.
- INC/CMA/AND: LDA 0xFFFF, INC -> AC=0x0000 with E unchanged. CMA -> AC=0xFFFF. AND 0x0F0F -> AC=0x0F0F. SNA -> skip=0. SPA -> skip=1.
- Handshake: cmd_valid held high with changing cmd_op -> only ops present in IDLE cycles execute. Reserved op 15 -> done=1, skip=0, no state change.
- Reset mid-op: ADD accepted, rst_n low during EXEC -> AC=0, E=0, ovf=0, no done pulse. cmd_ready=0 during reset and 1 in the first cycle after release.

Source files
------------

// File: rtl/ac_e_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ac_e_sequencer_if: command, ALU and status bundle for AC/E sequencer |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface ac_e_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_dr;

  logic [WIDTH-1:0] alu_ac;
  logic [WIDTH-1:0] alu_dr;
  logic             alu_e;
  logic [2:0]       alu_opsel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_co;
  logic             alu_ovf;

  logic [WIDTH-1:0] ac;
  logic             e;
  logic             ovf;
  logic             done;
  logic             skip;

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_dr, alu_result, alu_co, alu_ovf,
    output cmd_ready, alu_ac, alu_dr, alu_e, alu_opsel, ac, e, ovf, done, skip
  );

  // Control unit / ALU side
  modport master (
    output cmd_valid, cmd_op, cmd_dr, alu_result, alu_co, alu_ovf,
    input  cmd_ready, alu_ac, alu_dr, alu_e, alu_opsel, ac, e, ovf, done, skip
  );
endinterface
`default_nettype wire

// File: rtl/ac_e_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ac_e_sequencer: owns AC/E, drives the ALU, evaluates skip tests     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module ac_e_sequencer #(
  parameter int WIDTH = 16
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  ac_e_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_LDA = 4'd3;
  localparam logic [3:0] OP_CLA = 4'd4;
  localparam logic [3:0] OP_CLE = 4'd5;
  localparam logic [3:0] OP_CMA = 4'd6;
  localparam logic [3:0] OP_CME = 4'd7;
  localparam logic [3:0] OP_CIR = 4'd8;
  localparam logic [3:0] OP_CIL = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10;
  localparam logic [3:0] OP_SPA = 4'd11;
  localparam logic [3:0] OP_SNA = 4'd12;
  localparam logic [3:0] OP_SZA = 4'd13;
  localparam logic [3:0] OP_SZE = 4'd14;

  localparam logic [2:0] SEL_ADD  = 3'b000;
  localparam logic [2:0] SEL_AND  = 3'b001;
  localparam logic [2:0] SEL_XFER = 3'b010;
  localparam logic [2:0] SEL_CMA  = 3'b011;
  localparam logic [2:0] SEL_CIR  = 3'b100;
  localparam logic [2:0] SEL_CIL  = 3'b101;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] dr_q, dr_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic             e_q, e_d;
  logic             ovf_q, ovf_d;
  logic             skip_q, skip_d;

  logic             cmd_ready;
  logic             accept;
  logic [2:0]       opsel;
  logic             skip_cond;

  assign cmd_ready = (state_q == ST_IDLE) && rst_n;
  assign accept    = bus.cmd_valid && cmd_ready;

  // ALU select is only meaningful in EXEC; elsewhere it parks on transfer.
  always_comb begin
    opsel = SEL_XFER;
    if (state_q == ST_EXEC) begin
      case (op_q)
        OP_AND:         opsel = SEL_AND;
        OP_ADD, OP_INC: opsel = SEL_ADD;
        OP_LDA:         opsel = SEL_XFER;
        OP_CMA:         opsel = SEL_CMA;
        OP_CIR:         opsel = SEL_CIR;
        OP_CIL:         opsel = SEL_CIL;
        default:        opsel = SEL_XFER;
      endcase
    end
  end

  always_comb begin
    skip_cond = 1'b0;
    case (op_q)
      OP_SPA:  skip_cond = ~ac_q[WIDTH-1];
      OP_SNA:  skip_cond = ac_q[WIDTH-1];
      OP_SZA:  skip_cond = (ac_q == '0);
      OP_SZE:  skip_cond = ~e_q;
      default: skip_cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dr_d    = dr_q;
    ac_d    = ac_q;
    e_d     = e_q;
    ovf_d   = ovf_q;
    skip_d  = skip_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = bus.cmd_op;
          dr_d    = bus.cmd_dr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_DONE;
        skip_d  = skip_cond;
        case (op_q)
          OP_AND, OP_LDA, OP_CMA: ac_d = bus.alu_result;
          OP_ADD: begin
            ac_d  = bus.alu_result;
            e_d   = bus.alu_co;
            ovf_d = bus.alu_ovf;
          end
          OP_CIR, OP_CIL: begin
            ac_d = bus.alu_result;
            e_d  = bus.alu_co;
          end
          OP_INC: begin
            ac_d  = bus.alu_result;
            ovf_d = bus.alu_ovf;
          end
          OP_CLA:  ac_d = '0;
          OP_CLE:  e_d  = 1'b0;
          OP_CME:  e_d  = ~e_q;
          default: ;
        endcase
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        skip_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      dr_q    <= '0;
      ac_q    <= '0;
      e_q     <= 1'b0;
      ovf_q   <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dr_q    <= dr_d;
      ac_q    <= ac_d;
      e_q     <= e_d;
      ovf_q   <= ovf_d;
      skip_q  <= skip_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.alu_ac    = ac_q;
  assign bus.alu_e     = e_q;
  assign bus.alu_dr    = ((state_q == ST_EXEC) && (op_q == OP_INC)) ? ONE : dr_q;
  assign bus.alu_opsel = opsel;
  assign bus.ac        = ac_q;
  assign bus.e         = e_q;
  assign bus.ovf       = ovf_q;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.skip      = skip_q;

endmodule
`default_nettype wire

// File: tb/tb_ac_e_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ac_e_sequencer: directed + random checks against a Basic-Computer |
// | AC/E model, with a behavioural ALU attached.   Revision: 1.0        |
// +--------------------------------------------------------------------+
module tb_ac_e_sequencer;

  logic clk;
  logic rst_n;

  ac_e_sequencer_if #(.WIDTH(16)) bus ();

  ac_e_sequencer #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; non-arithmetic selects drive misleading flags on purpose.
  logic [16:0] alu_sum;
  always_comb begin
    alu_sum        = {1'b0, bus.alu_ac} + {1'b0, bus.alu_dr};
    bus.alu_result = bus.alu_dr;
    bus.alu_co     = ~bus.alu_e;
    bus.alu_ovf    = 1'b1;
    case (bus.alu_opsel)
      3'b000: begin
        bus.alu_result = alu_sum[15:0];
        bus.alu_co     = alu_sum[16];
        bus.alu_ovf    = (bus.alu_ac[15] == bus.alu_dr[15]) && (alu_sum[15] != bus.alu_ac[15]);
      end
      3'b001: bus.alu_result = bus.alu_ac & bus.alu_dr;
      3'b010: bus.alu_result = bus.alu_dr;
      3'b011: bus.alu_result = ~bus.alu_ac;
      3'b100: begin
        bus.alu_result = {bus.alu_e, bus.alu_ac[15:1]};
        bus.alu_co     = bus.alu_ac[0];
      end
      3'b101: begin
        bus.alu_result = {bus.alu_ac[14:0], bus.alu_e};
        bus.alu_co     = bus.alu_ac[15];
      end
      default: bus.alu_result = 16'hDEAD;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_ac;
  logic        m_e;
  logic        m_ovf;
  logic        m_skip;
  logic        last_skip;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ac = 16'h0; m_e = 1'b0; m_ovf = 1'b0; m_skip = 1'b0;
  endtask

  // Basic Computer semantics on the 17-bit {E,AC} pair.
  task automatic model_step(input logic [3:0] op, input logic [15:0] dr);
    logic [16:0] sum;
    m_skip = 1'b0;
    case (op)
      4'd1:  m_ac = m_ac & dr;
      4'd2: begin
        sum   = {1'b0, m_ac} + {1'b0, dr};
        m_ovf = (m_ac[15] == dr[15]) && (sum[15] != m_ac[15]);
        m_ac  = sum[15:0];
        m_e   = sum[16];
      end
      4'd3:  m_ac = dr;
      4'd4:  m_ac = 16'h0;
      4'd5:  m_e = 1'b0;
      4'd6:  m_ac = ~m_ac;
      4'd7:  m_e = ~m_e;
      4'd8:  {m_ac, m_e} = {m_e, m_ac};
      4'd9:  {m_e, m_ac} = {m_ac, m_e};
      4'd10: begin
        m_ovf = (m_ac == 16'h7FFF);
        m_ac  = m_ac + 16'd1;
      end
      4'd11: m_skip = (m_ac[15] == 1'b0);
      4'd12: m_skip = (m_ac[15] == 1'b1);
      4'd13: m_skip = (m_ac == 16'h0);
      4'd14: m_skip = (m_e == 1'b0);
      default: ;
    endcase
  endtask

  function automatic logic [2:0] exp_sel(input logic [3:0] op);
    case (op)
      4'd1:        return 3'b001;
      4'd2, 4'd10: return 3'b000;
      4'd6:        return 3'b011;
      4'd8:        return 3'b100;
      4'd9:        return 3'b101;
      default:     return 3'b010;
    endcase
  endfunction

  // Called on a falling edge; returns on the falling edge after the command retires.
  task automatic do_cmd(input logic [3:0] op, input logic [15:0] dr);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_dr    = dr;
    model_step(op, dr);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'($urandom);
    bus.cmd_dr    = 16'($urandom);
    check("exec_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("exec_done", {31'd0, bus.done}, 32'd0);
    check("exec_opsel", {29'd0, bus.alu_opsel}, {29'd0, exp_sel(op)});
    check("exec_alu_dr", {16'd0, bus.alu_dr}, {16'd0, (op == 4'd10) ? 16'd1 : dr});
    @(negedge clk);
    check("done_pulse", {31'd0, bus.done}, 32'd1);
    check("done_skip", {31'd0, bus.skip}, {31'd0, m_skip});
    check("done_ac", {16'd0, bus.ac}, {16'd0, m_ac});
    check("done_e", {31'd0, bus.e}, {31'd0, m_e});
    check("done_ovf", {31'd0, bus.ovf}, {31'd0, m_ovf});
    last_skip = bus.skip;
    @(negedge clk);
    check("post_done", {31'd0, bus.done}, 32'd0);
    check("post_ready", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  logic [3:0]  r_op;
  logic [15:0] r_dr;
  int          since;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'd0;
    bus.cmd_dr    = 16'd0;
    rst_n         = 1'b0;
    last_skip     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("rst_ac", {16'd0, bus.ac}, 32'd0);
    check("rst_e", {31'd0, bus.e}, 32'd0);
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_skip", {31'd0, bus.skip}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready", {31'd0, bus.cmd_ready}, 32'd1);
    @(negedge clk);

    // ADD overflow
    do_cmd(4'd3, 16'h7FFF);
    do_cmd(4'd2, 16'h0001);
    check("ovf_ac", {16'd0, bus.ac}, 32'h8000);
    check("ovf_e", {31'd0, bus.e}, 32'd0);
    check("ovf_flag", {31'd0, bus.ovf}, 32'd1);

    // ADD carry and zero tests
    do_cmd(4'd3, 16'hFFFF);
    do_cmd(4'd2, 16'h0001);
    check("carry_ac", {16'd0, bus.ac}, 32'h0);
    check("carry_e", {31'd0, bus.e}, 32'd1);
    check("carry_ovf", {31'd0, bus.ovf}, 32'd0);
    do_cmd(4'd13, 16'h1234);
    check("sza_skip", {31'd0, last_skip}, 32'd1);
    do_cmd(4'd14, 16'h0);
    check("sze_skip", {31'd0, last_skip}, 32'd0);

    // Rotates through E
    do_cmd(4'd5, 16'h0);
    do_cmd(4'd7, 16'h0);
    do_cmd(4'd3, 16'h8001);
    do_cmd(4'd9, 16'h0);
    check("cil_ac", {16'd0, bus.ac}, 32'h0003);
    check("cil_e", {31'd0, bus.e}, 32'd1);
    do_cmd(4'd5, 16'h0);
    do_cmd(4'd3, 16'h0001);
    do_cmd(4'd8, 16'h0);
    check("cir_ac", {16'd0, bus.ac}, 32'h0000);
    check("cir_e", {31'd0, bus.e}, 32'd1);

    // INC / CMA / AND / sign skips
    do_cmd(4'd3, 16'hFFFF);
    do_cmd(4'd10, 16'h5555);
    check("inc_ac", {16'd0, bus.ac}, 32'h0);
    check("inc_e", {31'd0, bus.e}, 32'd1);
    do_cmd(4'd6, 16'h0);
    check("cma_ac", {16'd0, bus.ac}, 32'hFFFF);
    do_cmd(4'd1, 16'h0F0F);
    check("and_ac", {16'd0, bus.ac}, 32'h0F0F);
    do_cmd(4'd12, 16'h0);
    check("sna_skip", {31'd0, last_skip}, 32'd0);
    do_cmd(4'd11, 16'h0);
    check("spa_skip", {31'd0, last_skip}, 32'd1);
    do_cmd(4'd15, 16'hFFFF);
    check("rsv_skip", {31'd0, last_skip}, 32'd0);
    check("rsv_ac", {16'd0, bus.ac}, 32'h0F0F);

    // cmd_valid held high; op changes every cycle, only IDLE-cycle ops count
    since = 3;
    for (int i = 0; i < 30; i++) begin
      check("hold_done", {31'd0, bus.done}, {31'd0, since == 2});
      check("hold_ready", {31'd0, bus.cmd_ready}, {31'd0, since >= 3});
      if (since == 2) begin
        check("hold_ac", {16'd0, bus.ac}, {16'd0, m_ac});
        check("hold_e", {31'd0, bus.e}, {31'd0, m_e});
        check("hold_ovf", {31'd0, bus.ovf}, {31'd0, m_ovf});
        check("hold_skip", {31'd0, bus.skip}, {31'd0, m_skip});
      end
      r_op = 4'($urandom);
      r_dr = 16'($urandom);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = r_op;
      bus.cmd_dr    = r_dr;
      if (bus.cmd_ready) begin
        model_step(r_op, r_dr);
        since = 0;
      end
      @(negedge clk);
      since++;
    end
    bus.cmd_valid = 1'b0;
    while (!bus.cmd_ready) @(negedge clk);

    // Reset during EXEC aborts an ADD
    do_cmd(4'd3, 16'h7FFF);
    do_cmd(4'd2, 16'h0001);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'd2;
    bus.cmd_dr    = 16'h8001;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    check("abort_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_ac", {16'd0, bus.ac}, 32'h0);
    check("abort_e", {31'd0, bus.e}, 32'd0);
    check("abort_ovf", {31'd0, bus.ovf}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("abort_rel_ready", {31'd0, bus.cmd_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, bus.done}, 32'd0);
    end

    // Random commands with corner-biased operands and idle gaps
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r_op = 4'($urandom);
      case ($urandom_range(0, 5))
        0:       r_dr = 16'h7FFF;
        1:       r_dr = 16'h8000;
        2:       r_dr = 16'hFFFF;
        3:       r_dr = 16'h0000;
        default: r_dr = 16'($urandom);
      endcase
      do_cmd(r_op, r_dr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
